heichips25_spi_cfg_bridge: RTL

Parametrised SPI front-end for the FPGA configuration port, the successor to the fixed, stubbed pad wiring of the core top level. In master mode it reads a bitstream from external SPI flash: READ 0x03, START_ADDR, then NUM_WORDS words. In slave mode it receives words clocked in by an external host. In both modes, assembled words go to the fabric config logic over a valid/ready stream, and the pad-side _o/_en_o triplets connect directly to the core's fpga_* pins.

---
 rtl/heichips25_spi_cfg_bridge_if.sv | 12 +
 rtl/heichips25_spi_cfg_bridge.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/heichips25_spi_cfg_bridge_if.sv
// Config-word stream between the SPI bridge (producer) and the fabric config logic (consumer).
`timescale 1ns/1ps
interface heichips25_spi_cfg_bridge_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] word_o;
    logic                  word_valid_o;
    logic                  word_ready_i;

    modport master (output word_o, word_valid_o, input word_ready_i);
    modport slave  (input word_o, word_valid_o, output word_ready_i);
endinterface

// File: rtl/heichips25_spi_cfg_bridge.sv
// SPI front-end for the FPGA config port: master mode streams a bitstream from flash,
// slave mode accepts words pushed by an external host. Both deliver words on cfg.
`timescale 1ns/1ps
module heichips25_spi_cfg_bridge #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_WORDS   = 1024,
    parameter int          CLK_DIV     = 2,
    parameter logic [23:0] START_ADDR  = 24'h000000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mode_i,
    input  logic start_i,
    input  logic sclk_i,
    output logic sclk_o,
    output logic sclk_en_o,
    input  logic cs_n_i,
    output logic cs_n_o,
    output logic cs_n_en_o,
    input  logic mosi_i,
    output logic mosi_o,
    output logic mosi_en_o,
    input  logic miso_i,
    output logic miso_o,
    output logic miso_en_o,
    heichips25_spi_cfg_bridge_if.master cfg,
    output logic busy_o,
    output logic done_o,
    output logic err_o
);
    localparam int CNT_MAX = (DATA_WIDTH > 24) ? DATA_WIDTH : 24;
    localparam int BIT_W   = $clog2(CNT_MAX);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WCNT_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [31:0] CMD_ADDR = {8'h03, START_ADDR};

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STALL, DONE} state_t;

    state_t                  state;
    logic                    mode_q;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [WCNT_W-1:0]       word_cnt;
    logic [31:0]             out_sr;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic                    sclk_prev;

    logic sclk_s, cs_s, mosi_s, host_rise;
    logic tick, word_bit_last, last_word, handshake;
    logic [DATA_WIDTH-1:0] m_next, s_next;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign host_rise = sclk_s & ~sclk_prev;

    assign tick          = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign word_bit_last = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign last_word     = (word_cnt == WCNT_W'(NUM_WORDS - 1));
    assign handshake     = cfg.word_valid_o & cfg.word_ready_i;
    assign m_next        = {shift_q[DATA_WIDTH-2:0], miso_i};
    assign s_next        = {shift_q[DATA_WIDTH-2:0], mosi_s};

    // The final word's handshake ends the load, so done/busy follow it combinationally.
    assign done_o    = (state == DONE) && handshake;
    assign busy_o    = (state != IDLE) && !done_o;
    assign sclk_en_o = mode_q;
    assign cs_n_en_o = mode_q;
    assign mosi_en_o = mode_q;
    assign miso_en_o = 1'b0;
    assign miso_o    = 1'b0;

    // Host pad synchronisers plus one extra flop of sclk for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_prev <= sclk_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            mode_q           <= 1'b0;
            sclk_o           <= 1'b0;
            cs_n_o           <= 1'b1;
            mosi_o           <= 1'b0;
            cfg.word_o       <= '0;
            cfg.word_valid_o <= 1'b0;
            err_o            <= 1'b0;
            div_cnt          <= '0;
            bit_cnt          <= '0;
            word_cnt         <= '0;
        end else begin
            if (handshake) cfg.word_valid_o <= 1'b0;
            if (state == IDLE) mode_q <= mode_i;

            if (mode_q) begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            state    <= CMD;
                            cs_n_o   <= 1'b0;
                            mosi_o   <= CMD_ADDR[31];
                            out_sr   <= {CMD_ADDR[30:0], 1'b0};
                            div_cnt  <= '0;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end
                    end
                    CMD, ADDR, DATA: begin
                        if (!tick) begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end else begin
                            div_cnt <= '0;
                            sclk_o  <= ~sclk_o;
                            if (!sclk_o) begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                if (state == CMD && bit_cnt == BIT_W'(7)) begin
                                    state   <= ADDR;
                                    bit_cnt <= '0;
                                end
                                if (state == ADDR && bit_cnt == BIT_W'(23)) begin
                                    state   <= DATA;
                                    bit_cnt <= '0;
                                end
                                if (state == DATA) begin
                                    shift_q <= m_next;
                                    if (word_bit_last) begin
                                        bit_cnt          <= '0;
                                        cfg.word_o       <= m_next;
                                        cfg.word_valid_o <= 1'b1;
                                        word_cnt         <= word_cnt + WCNT_W'(1);
                                        if (last_word) state <= DONE;
                                    end
                                end
                            end else begin
                                mosi_o <= (state == DATA) ? 1'b0 : out_sr[31];
                                out_sr <= {out_sr[30:0], 1'b0};
                                // Never begin a word while the output slot is still occupied
                                if (state == DATA && bit_cnt == '0 &&
                                    cfg.word_valid_o && !cfg.word_ready_i)
                                    state <= STALL;
                            end
                        end
                    end
                    STALL: begin
                        if (!cfg.word_valid_o || cfg.word_ready_i) state <= DATA;
                    end
                    DONE: begin
                        sclk_o <= 1'b0;
                        cs_n_o <= 1'b1;
                        if (handshake) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                if (cs_s) begin
                    bit_cnt <= '0;
                end else if (host_rise) begin
                    shift_q <= s_next;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (word_bit_last) begin
                        bit_cnt <= '0;
                        if (cfg.word_valid_o && !cfg.word_ready_i) begin
                            err_o <= 1'b1;
                        end else begin
                            cfg.word_o       <= s_next;
                            cfg.word_valid_o <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
